uart_cmd_parser: RTL and testbench

Frame parser sitting directly downstream of the UART receiver. It consumes the receiver's one-cycle byte-valid strobe and byte, assembles fixed 5-byte command frames (sync, cmd, addr, data, checksum), validates them, and issues single-cycle register write/read requests to the on-chip register bank. Malformed or stalled frames are discarded with an error pulse and code, so the host can resynchronise on the next sync byte.

---
 rtl/uart_cmd_pkg.sv | 37 +++
 rtl/uart_cmd_parser_if.sv | 24 ++
 rtl/uart_frame_timer.sv | 42 ++++
 rtl/uart_cmd_parser.sv | 142 ++++++++++++++
 tb/tb_uart_cmd_parser.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command parser: FSM states, command and
// error encodings, default sync byte, frame payload struct and checksum helper.
package uart_cmd_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned TMR_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_ADDR = 3'd2,
        S_DATA = 3'd3,
        S_CHK  = 3'd4
    } state_e;

    localparam logic [BYTE_W-1:0] CMD_WRITE    = 8'h01;
    localparam logic [BYTE_W-1:0] CMD_READ     = 8'h02;
    localparam logic [BYTE_W-1:0] SYNC_DEFAULT = 8'hA5;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_CHK  = 2'b01;
    localparam logic [1:0] ERR_CMD  = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    // Frame body latched between SYNC and CHK.
    typedef struct packed {
        logic [BYTE_W-1:0] cmd;
        logic [BYTE_W-1:0] addr;
        logic [BYTE_W-1:0] data;
    } frame_t;

    // Expected checksum byte: plain XOR of the three body bytes.
    function automatic logic [BYTE_W-1:0] frame_chk(input frame_t f);
        return f.cmd ^ f.addr ^ f.data;
    endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte stream in from the UART receiver and register-bank requests out.
//   master: receiver/host side (drives i_Rx_*, observes the rest)
//   slave : parser side (consumes i_Rx_*, drives requests and status)
interface uart_cmd_parser_if;
    logic       i_Rx_DV;
    logic [7:0] i_Rx_Byte;
    logic       o_Wr_En;
    logic       o_Rd_En;
    logic [7:0] o_Addr;
    logic [7:0] o_Wr_Data;
    logic       o_Frame_Err;
    logic [1:0] o_Err_Code;
    logic       o_Busy;

    modport master (
        output i_Rx_DV, i_Rx_Byte,
        input  o_Wr_En, o_Rd_En, o_Addr, o_Wr_Data, o_Frame_Err, o_Err_Code, o_Busy
    );

    modport slave (
        input  i_Rx_DV, i_Rx_Byte,
        output o_Wr_En, o_Rd_En, o_Addr, o_Wr_Data, o_Frame_Err, o_Err_Code, o_Busy
    );
endinterface

// File: rtl/uart_frame_timer.sv
// Inter-byte watchdog: 16-bit counter with synchronous clear and enable.
//   i_Clear     : zero the count (takes priority, also masks expiry)
//   i_Enable    : count while a frame is open
//   o_Expired_c : combinational, high while enabled at TIMEOUT_CLKS-1
module uart_frame_timer
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CLKS = 43400
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Clear,
    input  logic i_Enable,
    output logic o_Expired_c
);

    localparam logic [TMR_W-1:0] TERM = TMR_W'(TIMEOUT_CLKS - 1);

    logic [TMR_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, then increment, holding at the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (i_Clear) begin
            cnt_d = '0;
        end else if (i_Enable && (cnt_q != TERM)) begin
            cnt_d = cnt_q + TMR_W'(1);
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A byte arriving on the expiry cycle clears the timer, so it beats the timeout.
    assign o_Expired_c = i_Enable && !i_Clear && (cnt_q == TERM);

endmodule

// File: rtl/uart_cmd_parser.sv
// Fixed 5-byte frame parser (SYNC, CMD, ADDR, DATA, CHK) feeding the register bank.
//   i_Clock, i_Reset : clock, async active-low reset
//   bus (slave)      : byte strobe in; write/read pulses, address, write data,
//                      error pulse/code and busy flag out (all registered)
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE    = SYNC_DEFAULT,
    parameter int unsigned TIMEOUT_CLKS = 43400
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    uart_cmd_parser_if.slave  bus
);

    state_e      state_q, state_d;
    frame_t      frame_q, frame_d;
    logic        wr_en_q, wr_en_d;
    logic        rd_en_q, rd_en_d;
    logic        frame_err_q, frame_err_d;
    logic        busy_q, busy_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [1:0]  err_code_q, err_code_d;
    logic        tmo_c;
    logic        tmr_clear_c;
    logic        tmr_enable_c;

    assign tmr_enable_c = (state_q != S_IDLE);
    assign tmr_clear_c  = bus.i_Rx_DV || (state_q == S_IDLE);

    uart_frame_timer #(
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) u_timer (
        .i_Clock     (i_Clock),
        .i_Reset     (i_Reset),
        .i_Clear     (tmr_clear_c),
        .i_Enable    (tmr_enable_c),
        .o_Expired_c (tmo_c)
    );

    // Frame FSM: next state, byte latches and request/error outputs.
    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        frame_err_d = 1'b0;
        addr_d      = addr_q;
        wr_data_d   = wr_data_q;
        err_code_d  = err_code_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.i_Rx_DV && (bus.i_Rx_Byte == SYNC_BYTE)) begin
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (bus.i_Rx_DV) begin
                    frame_d.cmd = bus.i_Rx_Byte;
                    state_d     = S_ADDR;
                end
            end
            S_ADDR: begin
                if (bus.i_Rx_DV) begin
                    frame_d.addr = bus.i_Rx_Byte;
                    state_d      = S_DATA;
                end
            end
            S_DATA: begin
                if (bus.i_Rx_DV) begin
                    frame_d.data = bus.i_Rx_Byte;
                    state_d      = S_CHK;
                end
            end
            S_CHK: begin
                // Checksum is judged before the command so length stays fixed.
                if (bus.i_Rx_DV) begin
                    state_d = S_IDLE;
                    if (bus.i_Rx_Byte != frame_chk(frame_q)) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CHK;
                    end else if (frame_q.cmd == CMD_WRITE) begin
                        wr_en_d   = 1'b1;
                        addr_d    = frame_q.addr;
                        wr_data_d = frame_q.data;
                    end else if (frame_q.cmd == CMD_READ) begin
                        rd_en_d = 1'b1;
                        addr_d  = frame_q.addr;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CMD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Expiry is only possible on a cycle without a byte, so no overlap above.
        if (tmo_c) begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
            err_code_d  = ERR_TMO;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            state_q     <= S_IDLE;
            frame_q     <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
            addr_q      <= '0;
            wr_data_q   <= '0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
            addr_q      <= addr_d;
            wr_data_q   <= wr_data_d;
            err_code_q  <= err_code_d;
        end
    end

    assign bus.o_Wr_En     = wr_en_q;
    assign bus.o_Rd_En     = rd_en_q;
    assign bus.o_Frame_Err = frame_err_q;
    assign bus.o_Busy      = busy_q;
    assign bus.o_Addr      = addr_q;
    assign bus.o_Wr_Data   = wr_data_q;
    assign bus.o_Err_Code  = err_code_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser with a short inter-byte timeout.
module tb_uart_cmd_parser;

    localparam int unsigned TMO = 20;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   wr_cnt;
    int   rd_cnt;
    int   err_cnt;
    int   wr_base;
    int   rd_base;
    int   err_base;

    uart_cmd_parser_if bus_if ();

    uart_cmd_parser #(
        .SYNC_BYTE    (8'hA5),
        .TIMEOUT_CLKS (TMO)
    ) dut (
        .i_Clock (clk),
        .i_Reset (rst_n),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse tally, sampled mid-cycle so each one-cycle pulse counts once.
    always @(negedge clk) begin
        if (bus_if.o_Wr_En === 1'b1)     wr_cnt++;
        if (bus_if.o_Rd_En === 1'b1)     rd_cnt++;
        if (bus_if.o_Frame_Err === 1'b1) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives one byte for exactly one cycle and returns
    // at the following negedge, so calls chain into back-to-back strobes.
    task automatic send(input logic [7:0] b);
        bus_if.i_Rx_DV   = 1'b1;
        bus_if.i_Rx_Byte = b;
        @(negedge clk);
        bus_if.i_Rx_DV   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_outs(input string tag, input logic wr, input logic rd, input logic err,
                              input logic [7:0] addr, input logic [7:0] data, input logic [1:0] code,
                              input logic busy);
        chk({tag, ".wr"},   32'(bus_if.o_Wr_En),     32'(wr));
        chk({tag, ".rd"},   32'(bus_if.o_Rd_En),     32'(rd));
        chk({tag, ".err"},  32'(bus_if.o_Frame_Err), 32'(err));
        chk({tag, ".addr"}, 32'(bus_if.o_Addr),      32'(addr));
        chk({tag, ".data"}, 32'(bus_if.o_Wr_Data),   32'(data));
        chk({tag, ".code"}, 32'(bus_if.o_Err_Code),  32'(code));
        chk({tag, ".busy"}, 32'(bus_if.o_Busy),      32'(busy));
    endtask

    initial begin
        checks = 0; errors = 0; wr_cnt = 0; rd_cnt = 0; err_cnt = 0;
        rst_n = 1'b0;
        bus_if.i_Rx_DV   = 1'b0;
        bus_if.i_Rx_Byte = 8'h00;

        // Reset state
        idle(2);
        check_outs("reset", 0, 0, 0, 8'h00, 8'h00, 2'b00, 0);
        rst_n = 1'b1;
        idle(2);

        // Write frame
        send(8'hA5);
        chk("busy_after_sync", 32'(bus_if.o_Busy), 32'd1);
        send(8'h01); send(8'h10); send(8'h3C); send(8'h2D);
        check_outs("write", 1, 0, 0, 8'h10, 8'h3C, 2'b00, 0);
        idle(1);
        chk("write_single_pulse", 32'(bus_if.o_Wr_En), 32'd0);

        // Read frame: data byte ignored, write data held
        idle(2);
        send(8'hA5); send(8'h02); send(8'h20); send(8'h00); send(8'h22);
        check_outs("read", 0, 1, 0, 8'h20, 8'h3C, 2'b00, 0);
        idle(1);
        chk("read_single_pulse", 32'(bus_if.o_Rd_En), 32'd0);

        // Checksum fault, then bad command with a correct checksum
        send(8'hA5); send(8'h01); send(8'h10); send(8'h3C); send(8'h00);
        check_outs("chk_err", 0, 0, 1, 8'h20, 8'h3C, 2'b01, 0);
        idle(1);
        chk("chk_err_single_pulse", 32'(bus_if.o_Frame_Err), 32'd0);
        send(8'hA5); send(8'h07); send(8'h10); send(8'h3C); send(8'h2B);
        check_outs("cmd_err", 0, 0, 1, 8'h20, 8'h3C, 2'b10, 0);
        idle(1);

        // Timeout exactly TMO edges after the last accepted byte
        send(8'hA5); send(8'h01);
        idle(TMO - 1);
        check_outs("tmo_before", 0, 0, 0, 8'h20, 8'h3C, 2'b10, 1);
        idle(1);
        check_outs("tmo_pulse", 0, 0, 1, 8'h20, 8'h3C, 2'b11, 0);
        idle(1);
        chk("tmo_single_pulse", 32'(bus_if.o_Frame_Err), 32'd0);
        send(8'hA5); send(8'h01); send(8'h10); send(8'h3C); send(8'h2D);
        check_outs("after_tmo_write", 1, 0, 0, 8'h10, 8'h3C, 2'b11, 0);
        idle(1);

        // Byte landing on the expiry cycle beats the timeout
        send(8'hA5);
        idle(TMO - 1);
        send(8'h01);
        check_outs("dv_on_expiry", 0, 0, 0, 8'h10, 8'h3C, 2'b11, 1);
        send(8'h55); send(8'h66); send(8'h32);
        check_outs("dv_on_expiry_write", 1, 0, 0, 8'h55, 8'h66, 2'b11, 0);
        idle(1);

        // Sync value mid-frame is ordinary data
        send(8'hA5); send(8'h01); send(8'hA5); send(8'h3C); send(8'h98);
        check_outs("sync_as_addr", 1, 0, 0, 8'hA5, 8'h3C, 2'b11, 0);
        idle(1);

        // Garbage then back-to-back frames
        wr_base = wr_cnt; err_base = err_cnt;
        send(8'h00); send(8'hFF); send(8'h3C);
        chk("garbage_not_busy", 32'(bus_if.o_Busy), 32'd0);
        send(8'hA5); send(8'h01); send(8'h11); send(8'h22); send(8'h32);
        check_outs("b2b_first", 1, 0, 0, 8'h11, 8'h22, 2'b11, 0);
        send(8'hA5);
        chk("b2b_sync_accepted", 32'(bus_if.o_Busy), 32'd1);
        send(8'h01); send(8'h12); send(8'h34); send(8'h27);
        check_outs("b2b_second", 1, 0, 0, 8'h12, 8'h34, 2'b11, 0);
        idle(2);
        chk("b2b_two_writes", 32'(wr_cnt - wr_base), 32'd2);
        chk("b2b_no_errors", 32'(err_cnt - err_base), 32'd0);

        // Reset mid-frame discards the partial frame without a pulse
        wr_base = wr_cnt; rd_base = rd_cnt; err_base = err_cnt;
        send(8'hA5); send(8'h01); send(8'h10);
        rst_n = 1'b0;
        #1;
        check_outs("mid_reset", 0, 0, 0, 8'h00, 8'h00, 2'b00, 0);
        idle(3);
        rst_n = 1'b1;
        idle(TMO + 2);
        chk("mid_reset_no_wr", 32'(wr_cnt - wr_base), 32'd0);
        chk("mid_reset_no_rd", 32'(rd_cnt - rd_base), 32'd0);
        chk("mid_reset_no_err", 32'(err_cnt - err_base), 32'd0);
        chk("mid_reset_idle", 32'(bus_if.o_Busy), 32'd0);
        send(8'hA5); send(8'h01); send(8'h10); send(8'h3C); send(8'h2D);
        check_outs("post_reset_write", 1, 0, 0, 8'h10, 8'h3C, 2'b00, 0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
